instruction_fetch_unit: RTL

//  Producer side of the 16-bit COMMAND bus consumed by the decode unit. Owns the PC,

---
 rtl/simple_isa_pkg.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 95 +++++++++
 2 files changed

// File: rtl/simple_isa_pkg.sv
// Shared ISA definitions: instruction field layout, HLT detection
// and the fetch-unit state encoding.
package simple_isa_pkg;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] op3;
    logic [2:0] rsv;
    logic [3:0] func;
    logic [3:0] lo;
  } instr_t;

  localparam logic [1:0]  OP_SYS   = 2'b11;
  localparam logic [3:0]  FUNC_HLT = 4'b1111;
  localparam logic [15:0] CMD_NOP  = 16'hC0E0;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_HOLD,
    F_HALT
  } fetch_state_t;

  function automatic logic is_hlt(input logic [15:0] x);
    instr_t i;
    i = instr_t'(x);
    return (i.op == OP_SYS) && (i.func == FUNC_HLT);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the PC, fetches one word per req/ack from imem
// and presents it on COMMAND until decode takes it.
module instruction_fetch_unit
  import simple_isa_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [15:0]       IMEM_RDATA,
  output logic [15:0]       COMMAND,
  output logic              CMD_VALID,
  input  logic              STALL,
  input  logic              PC_load,
  input  logic [ADDR_W-1:0] PC_TARGET,
  output logic [ADDR_W-1:0] PC_PLUS1,
  output logic              HALTED,
  input  logic              RESTART
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [15:0]       cmd_q;
  logic              valid_q;
  logic              req_q;
  logic              halted_q;

  always_comb begin
    pc_inc = pc_q + ADDR_W'(1);
    pc_d   = PC_load ? PC_TARGET : pc_inc;
  end

  // Only the HOLD state consumes STALL/PC_load; other inputs are
  // ignored outside the state that owns them.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= F_IDLE;
      pc_q     <= RESET_PC;
      cmd_q    <= CMD_NOP;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        F_IDLE: begin
          state_q <= F_REQ;
          req_q   <= 1'b1;
        end
        F_REQ: begin
          if (IMEM_ACK) begin
            cmd_q   <= IMEM_RDATA;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= F_HOLD;
          end
        end
        F_HOLD: begin
          if (!STALL) begin
            valid_q <= 1'b0;
            if (is_hlt(cmd_q)) begin
              pc_q     <= pc_inc;
              halted_q <= 1'b1;
              state_q  <= F_HALT;
            end else begin
              pc_q    <= pc_d;
              req_q   <= 1'b1;
              state_q <= F_REQ;
            end
          end
        end
        F_HALT: begin
          if (RESTART) begin
            halted_q <= 1'b0;
            req_q    <= 1'b1;
            state_q  <= F_REQ;
          end
        end
      endcase
    end
  end

  assign IMEM_REQ  = req_q;
  assign IMEM_ADDR = pc_q;
  assign COMMAND   = cmd_q;
  assign CMD_VALID = valid_q;
  assign HALTED    = halted_q;
  assign PC_PLUS1  = pc_inc;

endmodule
